// File: rtl/apb_slave_mem.sv
// APB3 completer: byte-wide register file with a read-only tail region,
// fixed wait states and PSLVERR on out-of-range or read-only writes.
module apb_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int RO_BASE     = 56,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic                ready;
    logic [ADDR_W:0]     paddr_ext;

    assign paddr_ext = {1'b0, PADDR};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    write_d = PWRITE;
                    addr_d  = PADDR[IDX_W-1:0];
                    wdata_d = PWDATA;
                    err_d   = (paddr_ext >= (ADDR_W+1)'(DEPTH)) ||
                              (PWRITE && (paddr_ext >= (ADDR_W+1)'(RO_BASE)));
                end
            end
            ACCESS: begin
                // Losing PSEL or PENABLE mid-transfer is an abort, not a completion.
                if (!(PSEL && PENABLE)) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    mem_we  = write_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign ready   = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign PREADY  = ready;
    assign PSLVERR = ready && err_q;
    assign PRDATA  = (ready && !write_q && !err_q) ? mem_q[addr_q] : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: stimulus pushes expected completions,
// a negedge monitor pops and checks data, error flag and completion cycle.
module tb_apb_slave_mem;

    localparam int W = 2;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       PSEL = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE = 1'b0;
    logic [7:0] PADDR = '0;
    logic [7:0] PWDATA = '0;
    logic       PREADY;
    logic [7:0] PRDATA;
    logic       PSLVERR;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    apb_slave_mem #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(64), .RO_BASE(56), .WAIT_CYCLES(W)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (PREADY) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("prdata", int'(PRDATA), int'(e.rdata));
                    check("pslverr", int'(PSLVERR), int'(e.err));
                    check("pready_cycle", cyc, e.due);
                end
            end else begin
                check("pslverr_idle", int'(PSLVERR), 0);
                check("prdata_idle", int'(PRDATA), 0);
            end
        end
    end

    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] exp_rdata, input logic exp_err);
        exp_t e;
        bit   done;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        e.rdata = exp_rdata; e.err = exp_err; e.due = cyc + W + 1;
        sb.push_back(e);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR = ~addr;
        PWDATA = ~data;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (PREADY) done = 1'b1;
        end
        if (!done) begin
            check("pready_timeout", 0, 1);
            void'(sb.pop_front());
        end
    endtask

    task automatic go_idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        check("reset_pready", int'(PREADY), 0);
        check("reset_prdata", int'(PRDATA), 0);
        check("reset_pslverr", int'(PSLVERR), 0);

        for (int a = 0; a < 64; a++) xfer(1'b0, 8'(a), 8'h00, 8'h00, 1'b0);

        xfer(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        xfer(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

        xfer(1'b1, 8'h40, 8'h3C, 8'h00, 1'b1);
        xfer(1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
        xfer(1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);

        xfer(1'b1, 8'h37, 8'h5A, 8'h00, 1'b0);
        xfer(1'b0, 8'h37, 8'h00, 8'h5A, 1'b0);
        xfer(1'b1, 8'h38, 8'hFF, 8'h00, 1'b1);
        xfer(1'b0, 8'h38, 8'h00, 8'h00, 1'b0);
        xfer(1'b1, 8'h3F, 8'h11, 8'h00, 1'b1);
        xfer(1'b0, 8'h3F, 8'h00, 8'h00, 1'b0);
        go_idle();

        // Abort: PSEL dropped in the first wait cycle.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h05; PWDATA = 8'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(posedge PCLK);
        xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
        go_idle();

        // Reset pulse in the middle of a write.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h07; PWDATA = 8'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESETn = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        check("rst_mid_pready", int'(PREADY), 0);
        check("rst_mid_prdata", int'(PRDATA), 0);
        check("rst_mid_pslverr", int'(PSLVERR), 0);
        xfer(1'b0, 8'h07, 8'h00, 8'h00, 1'b0);
        xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
        xfer(1'b0, 8'h37, 8'h00, 8'h00, 1'b0);
        go_idle();

        // Stray access phase with no setup phase.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h11; PWDATA = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("stray_pready", int'(PREADY), 0);
        end
        go_idle();
        xfer(1'b0, 8'h11, 8'h00, 8'h00, 1'b0);
        xfer(1'b1, 8'h00, 8'hC3, 8'h00, 1'b0);
        xfer(1'b0, 8'h00, 8'h00, 8'hC3, 1'b0);
        go_idle();

        repeat (3) @(posedge PCLK);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
